// File: rtl/alu74181_pkg.sv
// Shared types and constants for the 74181 nibble sequencer.
// ALU_SETTLE_EN adds a SETTLE state between DRIVE and SAMPLE.
package alu74181_pkg;

    localparam int NIBBLES_DEF = 4;

    // 74181 select codes for the common operations
    localparam logic [3:0] S_ADD = 4'b1001;  // M=0: A plus B
    localparam logic [3:0] S_SUB = 4'b0110;  // M=0: A minus B minus 1 (plus carry)
    localparam logic [3:0] S_XOR = 4'b0110;  // M=1: A xor B
    localparam logic [3:0] S_AND = 4'b1011;  // M=1: A and B

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
`ifdef ALU_SETTLE_EN
        ST_SETTLE,
`endif
        ST_SAMPLE,
        ST_DONE
    } state_e;

endpackage

// File: rtl/alu74181_seq.sv
// Runs an external 4-bit 74181 core over NIBBLES nibbles, LSB first,
// chaining the active-low carry and reassembling the wide result.
// ALU_SETTLE_EN inserts SETTLE_CYCLES wait cycles after every DRIVE,
// for builds where the core sits behind slow pads.
import alu74181_pkg::*;

module alu74181_seq #(
    parameter int NIBBLES       = NIBBLES_DEF,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clock,
    input  logic                 resetb,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_m,
    input  logic [3:0]           cmd_s,
    input  logic                 cmd_cn,
    input  logic [4*NIBBLES-1:0] cmd_a,
    input  logic [4*NIBBLES-1:0] cmd_b,
    output logic                 alu_m,
    output logic [3:0]           alu_s,
    output logic                 alu_cn,
    output logic [3:0]           alu_a,
    output logic [3:0]           alu_b,
    input  logic [3:0]           alu_f,
    input  logic                 alu_cn4,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [4*NIBBLES-1:0] rsp_f,
    output logic                 rsp_cn4,
    output logic                 rsp_allones
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               m_q, m_d, cn_q, cn_d;
    logic [3:0]         s_q, s_d;
    logic [W-1:0]       a_q, a_d, b_q, b_d;
    logic               alu_m_q, alu_m_d, alu_cn_q, alu_cn_d;
    logic [3:0]         alu_s_q, alu_s_d, alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [W-1:0]       rsp_f_q, rsp_f_d;
    logic               cn4_q, cn4_d;   // carry of last sampled nibble
`ifdef ALU_SETTLE_EN
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);
    logic [3:0]         cnt_q, cnt_d;
`endif

    // Next-state, operand latch, core drive and result assembly
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        m_d      = m_q;
        s_d      = s_q;
        cn_d     = cn_q;
        a_d      = a_q;
        b_d      = b_q;
        alu_m_d  = alu_m_q;
        alu_s_d  = alu_s_q;
        alu_cn_d = alu_cn_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        rsp_f_d  = rsp_f_q;
        cn4_d    = cn4_q;
`ifdef ALU_SETTLE_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    m_d     = cmd_m;
                    s_d     = cmd_s;
                    cn_d    = cmd_cn;
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    idx_d   = '0;
                    rsp_f_d = '0;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                alu_m_d  = m_q;
                alu_s_d  = s_q;
                alu_a_d  = a_q[{idx_q, 2'b00} +: 4];
                alu_b_d  = b_q[{idx_q, 2'b00} +: 4];
                // first nibble takes the command carry, the rest ripple
                alu_cn_d = (idx_q == '0) ? cn_q : cn4_q;
`ifdef ALU_SETTLE_EN
                cnt_d    = SETTLE_INIT;
                state_d  = ST_SETTLE;
`else
                state_d  = ST_SAMPLE;
`endif
            end
`ifdef ALU_SETTLE_EN
            ST_SETTLE: begin
                if (cnt_q == '0) state_d = ST_SAMPLE;
                else             cnt_d   = cnt_q - 4'd1;
            end
`endif
            ST_SAMPLE: begin
                rsp_f_d[{idx_q, 2'b00} +: 4] = alu_f;
                cn4_d = alu_cn4;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_DRIVE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // registered ready: high exactly while sitting in IDLE
        cmd_ready_d = (state_d == ST_IDLE);
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            cmd_ready_q <= 1'b0;
            m_q         <= 1'b1;
            s_q         <= 4'd0;
            cn_q        <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
            alu_m_q     <= 1'b1;
            alu_s_q     <= 4'd0;
            alu_cn_q    <= 1'b1;
            alu_a_q     <= 4'd0;
            alu_b_q     <= 4'd0;
            rsp_f_q     <= '0;
            cn4_q       <= 1'b1;
`ifdef ALU_SETTLE_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cmd_ready_q <= cmd_ready_d;
            m_q         <= m_d;
            s_q         <= s_d;
            cn_q        <= cn_d;
            a_q         <= a_d;
            b_q         <= b_d;
            alu_m_q     <= alu_m_d;
            alu_s_q     <= alu_s_d;
            alu_cn_q    <= alu_cn_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            rsp_f_q     <= rsp_f_d;
            cn4_q       <= cn4_d;
`ifdef ALU_SETTLE_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign alu_m       = alu_m_q;
    assign alu_s       = alu_s_q;
    assign alu_cn      = alu_cn_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign rsp_valid   = (state_q == ST_DONE);
    assign rsp_f       = rsp_f_q;
    assign rsp_cn4     = cn4_q;
    assign rsp_allones = &rsp_f_q;

endmodule

// File: tb/tb_alu74181_seq.sv
// Bench for alu74181_seq: behavioural 74181 core on the alu_* ports,
// fixed vector table, random ops against a wide-arithmetic model,
// plus backpressure and mid-op reset sequences.
module tb_alu74181_seq;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;
`ifdef ALU_SETTLE_EN
    localparam int SC  = 3;
`else
    localparam int SC  = 0;
`endif
    localparam int LAT = NIB * (2 + SC) + 1;

    logic clock = 1'b0, resetb = 1'b0;
    logic cmd_valid = 1'b0, cmd_m = 1'b0, cmd_cn = 1'b1, rsp_ready = 1'b0;
    logic [3:0] cmd_s = 4'd0;
    logic [W-1:0] cmd_a = '0, cmd_b = '0;
    logic cmd_ready, alu_m, alu_cn, alu_cn4, rsp_valid, rsp_cn4, rsp_allones;
    logic [3:0] alu_s, alu_a, alu_b, alu_f;
    logic [W-1:0] rsp_f;
    logic [32:0] core_out;

    int total = 0, bad = 0, cyc = 0;

    alu74181_seq #(.NIBBLES(NIB), .SETTLE_CYCLES(3)) dut (
        .clock(clock), .resetb(resetb),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_m(cmd_m), .cmd_s(cmd_s),
        .cmd_cn(cmd_cn), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_m(alu_m), .alu_s(alu_s), .alu_cn(alu_cn), .alu_a(alu_a), .alu_b(alu_b),
        .alu_f(alu_f), .alu_cn4(alu_cn4),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_f(rsp_f),
        .rsp_cn4(rsp_cn4), .rsp_allones(rsp_allones)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // 74181 function at any width w: arithmetic is X plus Y plus carry,
    // Cn and Cn+4 active-low. Returns {cn4, f}.
    function automatic logic [32:0] ref74181(input logic m, input logic [3:0] s, input logic cn,
                                             input logic [31:0] a, input logic [31:0] b, input int w);
        logic [32:0] mask, sum;
        logic [31:0] x, y, f, ones;
        mask = (33'd1 << w) - 33'd1;
        ones = mask[31:0];
        case (s)
            4'b0000: begin x = a;       y = 0;    end
            4'b0001: begin x = a | b;   y = 0;    end
            4'b0010: begin x = a | ~b;  y = 0;    end
            4'b0011: begin x = 0;       y = ones; end
            4'b0100: begin x = a;       y = a & ~b; end
            4'b0101: begin x = a | b;   y = a & ~b; end
            4'b0110: begin x = a;       y = ~b;   end
            4'b0111: begin x = a & ~b;  y = ones; end
            4'b1000: begin x = a;       y = a & b; end
            4'b1001: begin x = a;       y = b;    end
            4'b1010: begin x = a | ~b;  y = a & b; end
            4'b1011: begin x = a & b;   y = ones; end
            4'b1100: begin x = a;       y = a;    end
            4'b1101: begin x = a | b;   y = a;    end
            4'b1110: begin x = a | ~b;  y = a;    end
            default: begin x = a;       y = ones; end
        endcase
        sum = ({1'b0, x} & mask) + ({1'b0, y} & mask) + {32'd0, ~cn};
        if (m) begin
            case (s)
                4'b0000: f = ~a;        4'b0001: f = ~(a | b);
                4'b0010: f = ~a & b;    4'b0011: f = 0;
                4'b0100: f = ~(a & b);  4'b0101: f = ~b;
                4'b0110: f = a ^ b;     4'b0111: f = a & ~b;
                4'b1000: f = ~a | b;    4'b1001: f = ~(a ^ b);
                4'b1010: f = b;         4'b1011: f = a & b;
                4'b1100: f = ones;      4'b1101: f = a | ~b;
                4'b1110: f = a | b;     default: f = a;
            endcase
        end else begin
            f = sum[31:0];
        end
        return {~sum[w], f & ones};
    endfunction

    // the combinational core the sequencer drives
    assign core_out = ref74181(alu_m, alu_s, alu_cn, {28'd0, alu_a}, {28'd0, alu_b}, 4);
    assign alu_f    = core_out[3:0];
    assign alu_cn4  = core_out[32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Waits (bounded) for rsp_valid starting at a negedge.
    task automatic wait_rsp(output bit ok);
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (rsp_valid) begin ok = 1; break; end
            @(negedge clock);
        end
    endtask

    // Full command/response transaction; called at a negedge.
    task automatic do_op(input logic m, input logic [3:0] s, input logic cn,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] f, output logic c4, output logic ao,
                         output int lat, output bit m_ok);
        int acc;
        bit got;
        cmd_valid = 1; cmd_m = m; cmd_s = s; cmd_cn = cn; cmd_a = a; cmd_b = b;
        got = 0; f = 'x; c4 = 1'bx; ao = 1'bx; lat = -1; m_ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) begin got = 1; break; end
            @(negedge clock);
        end
        acc = cyc;
        @(negedge clock);
        cmd_valid = 0;
        if (!got) begin chk("accept_timeout", 0, 1); return; end
        m_ok = 1; got = 0;
        for (int i = 0; i < 300; i++) begin
            if (rsp_valid) begin got = 1; break; end
            if (cyc - acc >= 2 && alu_m !== m) m_ok = 0;
            @(negedge clock);
        end
        if (!got) begin chk("rsp_timeout", 0, 1); return; end
        lat = cyc - acc; f = rsp_f; c4 = rsp_cn4; ao = rsp_allones;
        rsp_ready = 1;
        @(negedge clock);
        rsp_ready = 0;
    endtask

    typedef struct {
        logic m; logic [3:0] s; logic cn;
        logic [W-1:0] a, b, f;
        logic cn4; bit chk_cn4; logic ao;
    } vec_t;

    vec_t vt[7];

    initial begin
        logic [W-1:0] f, f0;
        logic c4, ao;
        logic [32:0] exp;
        int lat, h, acc;
        bit m_ok, ok;

        vt[0] = '{1'b0, 4'b1001, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1, 1'b0};
        vt[1] = '{1'b0, 4'b0110, 1'b0, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1, 1'b0};
        vt[2] = '{1'b0, 4'b0110, 1'b1, 16'h1234, 16'h1234, 16'hFFFF, 1'b1, 1, 1'b1};
        vt[3] = '{1'b1, 4'b0110, 1'b1, 16'hA5A5, 16'h0F0F, 16'hAAAA, 1'b0, 0, 1'b0};
        vt[4] = '{1'b1, 4'b1011, 1'b1, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 0, 1'b0};
        vt[5] = '{1'b0, 4'b1001, 1'b1, 16'h00FF, 16'h0001, 16'h0100, 1'b1, 1, 1'b0};
        vt[6] = '{1'b0, 4'b1001, 1'b0, 16'h7FFF, 16'h0000, 16'h8000, 1'b1, 1, 1'b0};

        // reset values
        repeat (2) @(negedge clock);
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_f", 32'(rsp_f), 0);
        chk("rst_rsp_cn4", 32'(rsp_cn4), 1);
        chk("rst_allones", 32'(rsp_allones), 0);
        chk("rst_alu", {alu_m, alu_s, alu_cn, alu_a, alu_b}, {1'b1, 4'd0, 1'b1, 8'd0});
        resetb = 1;
        @(negedge clock);
        chk("ready_after_rst", 32'(cmd_ready), 1);

        // directed table
        for (int i = 0; i < 7; i++) begin
            do_op(vt[i].m, vt[i].s, vt[i].cn, vt[i].a, vt[i].b, f, c4, ao, lat, m_ok);
            chk($sformatf("vec%0d_f", i), 32'(f), 32'(vt[i].f));
            if (vt[i].chk_cn4) chk($sformatf("vec%0d_cn4", i), 32'(c4), 32'(vt[i].cn4));
            chk($sformatf("vec%0d_allones", i), 32'(ao), 32'(vt[i].ao));
            chk($sformatf("vec%0d_latency", i), lat, LAT);
            chk($sformatf("vec%0d_alu_m", i), 32'(m_ok), 1);
        end

        // random ops against the wide model
        for (int i = 0; i < 30; i++) begin
            logic rm, rcn;
            logic [3:0] rs;
            logic [W-1:0] ra, rb;
            rm = 1'($urandom); rcn = 1'($urandom); rs = 4'($urandom);
            ra = W'($urandom); rb = W'($urandom);
            exp = ref74181(rm, rs, rcn, {16'd0, ra}, {16'd0, rb}, W);
            do_op(rm, rs, rcn, ra, rb, f, c4, ao, lat, m_ok);
            chk($sformatf("rnd%0d_f m=%0d s=%h", i, rm, rs), 32'(f), 32'(exp[W-1:0]));
            chk($sformatf("rnd%0d_cn4", i), 32'(c4), 32'(exp[32]));
            chk($sformatf("rnd%0d_allones", i), 32'(ao), 32'(&exp[W-1:0]));
        end

        // backpressure: hold rsp_ready low, offer a second command meanwhile
        cmd_valid = 1; cmd_m = 0; cmd_s = 4'b0110; cmd_cn = 0; cmd_a = 16'h5678; cmd_b = 16'h1234;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) begin ok = 1; break; end
            @(negedge clock);
        end
        @(negedge clock);
        cmd_valid = 0;
        chk("bp_accept", 32'(ok), 1);
        wait_rsp(ok);
        chk("bp_rsp_arrives", 32'(ok), 1);
        f0 = rsp_f;
        chk("bp_first_f", 32'(f0), 32'h4444);
        cmd_valid = 1; cmd_m = 0; cmd_s = 4'b1001; cmd_cn = 1; cmd_a = 16'h1111; cmd_b = 16'h2222;
        ok = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (!rsp_valid || rsp_f !== 16'h4444 || cmd_ready) ok = 0;
        end
        chk("bp_hold_stable", 32'(ok), 1);
        rsp_ready = 1;
        h = cyc;
        @(negedge clock);
        rsp_ready = 0;
        chk("bp_ready_after_hs", 32'(cmd_ready), 1);
        acc = cyc;
        chk("bp_accept_gap", acc - h, 1);
        @(negedge clock);
        cmd_valid = 0;
        wait_rsp(ok);
        chk("bp_second_latency", ok ? cyc - acc : -1, LAT);
        chk("bp_second_f", 32'(rsp_f), 32'h3333);
        rsp_ready = 1;
        @(negedge clock);
        rsp_ready = 0;

        // reset in the middle of an add
        cmd_valid = 1; cmd_m = 0; cmd_s = 4'b1001; cmd_cn = 1; cmd_a = 16'h0FFF; cmd_b = 16'h0F01;
        chk("mid_rst_ready", 32'(cmd_ready), 1);
        @(negedge clock);
        cmd_valid = 0;
        repeat (4) @(negedge clock);
        resetb = 0;
        #1;
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
        chk("mid_rst_outs", {cmd_ready, rsp_f, rsp_cn4, rsp_allones},
            {1'b0, 16'h0000, 1'b1, 1'b0});
        chk("mid_rst_alu", {alu_m, alu_s, alu_cn, alu_a, alu_b}, {1'b1, 4'd0, 1'b1, 8'd0});
        ok = 1;
        repeat (3) begin
            @(negedge clock);
            if (rsp_valid) ok = 0;
        end
        resetb = 1;
        repeat (LAT + 2) begin
            @(negedge clock);
            if (rsp_valid) ok = 0;
        end
        chk("mid_rst_no_rsp", 32'(ok), 1);
        do_op(1'b0, 4'b1001, 1'b1, 16'h0FFF, 16'h0F01, f, c4, ao, lat, m_ok);
        chk("post_rst_f", 32'(f), 32'h1F00);
        chk("post_rst_latency", lat, LAT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
